key_event_scheduler: RTL and testbench
======================================

Name: key_event_scheduler

Overview:
- Sits between the bank of per-button debouncers and the calculator control FSM.
- Collects one-cycle "pressed" pulses and held-state levels from N debounced buttons.
- Adds auto-repeat for held buttons.
- Shares the single event channel among the buttons through round-robin arbitration, and presents one key event at a time on a valid/ready handshake.

Parameters:
- N_BTN, 5, number of debounced buttons (2..16).
- CODE_W, 3, width of the event code; must satisfy 2^CODE_W >= N_BTN.
- HOLD_DLY, 50000000, cycles a button is held after its press before the first repeat (>= 2).
- RPT_PERIOD, 10000000, cycles between subsequent repeats (>= 2).
- CNT_W, 27, width of the hold/repeat counter; must hold max(HOLD_DLY, RPT_PERIOD).
- RPT_MASK, all ones (N_BTN bits), per-button auto-repeat enable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- btn_down  in  N_BTN  one-cycle press pulses from the debouncers.
- btn_state  in  N_BTN  held levels from the debouncers (1 = pressed).
- evt_valid  out  1  an event is presented.
- evt_ready  in  1  consumer accepts the event.
- evt_code  out  CODE_W  index of the event's button.
- evt_repeat  out  1  1 = auto-repeat event, 0 = fresh press.
- evt_drop  out  1  one-cycle pulse when an event is lost.

Behaviour:
- Reset: clk is the only clock. With rst_n=0 at a clk edge, the following are all cleared:
  - evt_valid, evt_code, evt_repeat, evt_drop;
  - pending[] and pend_rpt[];
  - the round-robin pointer (index 0 gets first priority);
  - the repeat tracker (idle), with its counter at 0.
- Reset mid-operation discards any presented or pending event. No event is emitted for buttons still held at reset release until a new btn_down arrives.
- Pending register:
  - pending[i] is set on btn_down[i] with pend_rpt[i]=0, or on a repeat tick for i with pend_rpt[i]=1.
  - pending[i] is cleared when i is granted.
  - If i is granted and a new set for i arrives in the same cycle, the set wins: pending stays 1 with the new pend_rpt.
  - A set to a pending[i] that is already 1 and not granted that cycle keeps the existing entry. The new event is lost and evt_drop pulses for 1 cycle.
- Output register:
  - The output slot is free when evt_valid=0, or when evt_valid=1 and evt_ready=1.
  - When the slot is free and pending is non-zero, grant the first set bit searching upward from ptr and wrapping at N_BTN-1 to 0.
  - On a grant: load evt_code=index and evt_repeat=pend_rpt[index], set evt_valid=1, and set ptr=(index+1) mod N_BTN.
  - When the slot is free and nothing is pending, evt_valid goes to 0.
  - evt_code and evt_repeat are held stable while evt_valid=1 and evt_ready=0.
- Latency: btn_down at edge t sets pending at t. evt_valid is high after edge t+1 if the slot is free. Back-to-back accepts sustain 1 event per cycle.
- Repeat tracker:
  - On any btn_down, the tracker follows the lowest-index bit of btn_down that has RPT_MASK set. The counter resets to 0 and the phase becomes HOLD.
  - If no bit of btn_down has RPT_MASK set, the tracker goes idle.
  - In HOLD or RPT, with btn_state[trk]=1, the counter increments each cycle.
  - In HOLD, when the counter reaches HOLD_DLY-1: emit a repeat tick, set the counter to 0, and move to RPT.
  - In RPT, when the counter reaches RPT_PERIOD-1: emit a tick and set the counter to 0.
  - btn_state[trk]=0 sends the tracker to idle immediately, and no tick is emitted that cycle.
  - A btn_down and a tick in the same cycle: btn_down retargets the tracker, and the tick for the old button is still posted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with btn_down=5'b00001 -> evt_valid=0 and evt_drop=0 throughout and after release; no event appears.
- Single press: pulse btn_down[2] at edge t with evt_ready=1 -> evt_valid=1, evt_code=2, evt_repeat=0 for exactly 1 cycle after edge t+1.
- Simultaneous presses with ptr=0: pulse btn_down=5'b10110 with evt_ready=0 for 4 cycles, then evt_ready=1 -> codes 1, 2, 4 in order; ptr ends at 0.
- Drop: with evt_ready=0, pulse btn_down[3] at t, t+1 and t+3 -> the first is presented, the t+1 pulse pends, and the t+3 pulse gives evt_drop=1 one cycle later; exactly 2 events with code 3 are delivered once ready.
- Auto-repeat with HOLD_DLY=8, RPT_PERIOD=4: press button 1 and hold for 20 cycles with ready=1 -> press event, then evt_repeat=1 events at press+8 and every 4 cycles after; none after release.
- Retarget: with button 0 held in RPT, press button 4 and hold both -> button 0 repeats stop, button 4 repeats start HOLD_DLY cycles after its press.

Source files
------------

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: collects debounced presses, adds auto-repeat,
// arbitrates round-robin and presents one key event on valid/ready.
module key_event_scheduler #(
  parameter int N_BTN = 5,
  parameter int CODE_W = 3,
  parameter int HOLD_DLY = 50000000,
  parameter int RPT_PERIOD = 10000000,
  parameter int CNT_W = 27,
  parameter logic [N_BTN-1:0] RPT_MASK = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_down,
  input  logic [N_BTN-1:0]  btn_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_repeat,
  output logic              evt_drop
);

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_HOLD,
    TRK_RPT
  } trk_phase_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CODE_W-1:0] LAST   = CODE_W'(N_BTN - 1);

  trk_phase_t        phase, phase_n;
  logic [CODE_W-1:0] trk, trk_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              tick;
  logic [N_BTN-1:0]  tick_vec;
  logic [N_BTN-1:0]  mask_down;
  logic [CODE_W-1:0] low_idx;

  logic [N_BTN-1:0]  pending, pend_n;
  logic [N_BTN-1:0]  pend_rpt, rpt_n;
  logic [N_BTN-1:0]  set_vec;
  logic [N_BTN-1:0]  grant_vec;
  logic [CODE_W-1:0] ptr, nxt_ptr;
  logic [CODE_W-1:0] gidx;
  logic              found;
  logic              grant;
  logic              free;
  logic              drop_n;
  int                j;

  assign mask_down = btn_down & RPT_MASK;
  assign free      = ~evt_valid | evt_ready;
  assign grant     = found & free;
  assign set_vec   = btn_down | tick_vec;

  // Lowest-index repeat-enabled press becomes the tracked button.
  always_comb begin
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (mask_down[i]) low_idx = CODE_W'(i);
    end
  end

  // Repeat tracker state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= TRK_IDLE;
      trk   <= '0;
      cnt   <= '0;
    end else begin
      phase <= phase_n;
      trk   <= trk_n;
      cnt   <= cnt_n;
    end
  end

  // Tracker next state: count while held, tick at hold/period limits.
  always_comb begin
    phase_n = phase;
    trk_n   = trk;
    cnt_n   = cnt;
    tick    = 1'b0;
    case (phase)
      TRK_HOLD, TRK_RPT: begin
        if (!btn_state[trk]) begin
          phase_n = TRK_IDLE;
          cnt_n   = '0;
        end else if (cnt == ((phase == TRK_HOLD) ? HOLD_LIM : RPT_LIM)) begin
          tick    = 1'b1;
          cnt_n   = '0;
          phase_n = TRK_RPT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        phase_n = TRK_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (|mask_down) begin
      phase_n = TRK_HOLD;
      trk_n   = low_idx;
      cnt_n   = '0;
    end else if (|btn_down) begin
      phase_n = TRK_IDLE;
      cnt_n   = '0;
    end
  end

  // Tick decoded onto the tracked button's pending slot.
  always_comb begin
    tick_vec = '0;
    if (tick) tick_vec[trk] = 1'b1;
  end

  // Round-robin search upward from ptr, wrapping at the last button.
  always_comb begin
    found     = 1'b0;
    gidx      = '0;
    grant_vec = '0;
    nxt_ptr   = ptr;
    j         = 0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!found && pending[j]) begin
        found = 1'b1;
        gidx  = CODE_W'(j);
      end
    end
    if (grant) begin
      grant_vec[gidx] = 1'b1;
      nxt_ptr = (gidx == LAST) ? '0 : gidx + 1'b1;
    end
  end

  // Pending update: a new set beats a same-cycle grant; a set onto an
  // occupied, ungranted slot is lost. A press and a tick on the same
  // button together lose the tick.
  always_comb begin
    pend_n = pending;
    rpt_n  = pend_rpt;
    drop_n = |(btn_down & tick_vec);
    for (int i = 0; i < N_BTN; i++) begin
      if (set_vec[i] && (!pending[i] || grant_vec[i])) begin
        pend_n[i] = 1'b1;
        rpt_n[i]  = ~btn_down[i];
      end else if (set_vec[i]) begin
        drop_n = 1'b1;
      end else if (grant_vec[i]) begin
        pend_n[i] = 1'b0;
      end
    end
  end

  // Pending bank, pointer and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      pend_rpt   <= '0;
      ptr        <= '0;
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_repeat <= 1'b0;
      evt_drop   <= 1'b0;
    end else begin
      pending  <= pend_n;
      pend_rpt <= rpt_n;
      evt_drop <= drop_n;
      if (free) begin
        if (grant) begin
          evt_valid  <= 1'b1;
          evt_code   <= gidx;
          evt_repeat <= pend_rpt[gidx];
          ptr        <= nxt_ptr;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed scenarios with hand-computed
// expectations for the key event scheduler.
module tb_key_event_scheduler;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_down;
  logic [4:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic       evt_repeat;
  logic       evt_drop;

  int n_cmp;
  int n_err;

  key_event_scheduler #(
    .N_BTN(5),
    .CODE_W(3),
    .HOLD_DLY(8),
    .RPT_PERIOD(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_down(btn_down),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_repeat(evt_repeat),
    .evt_drop(evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_down = 5'b00001;
    btn_state = 5'b00001;
    evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (evt_valid !== 1'b0 || evt_drop !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d: valid=%b drop=%b want 0 0",
                 c, evt_valid, evt_drop);
      end
    end
    n_cmp++;
    if (evt_code !== 3'd0 || evt_repeat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs: code=%0d rpt=%b want 0 0",
               evt_code, evt_repeat);
    end
    rst_n = 1'b1;
    btn_down = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if (evt_valid !== 1'b0 || evt_drop !== 1'b0) begin
        n_err++;
        $display("FAIL reset_after c=%0d: valid=%b drop=%b want 0 0",
                 c, evt_valid, evt_drop);
      end
    end
    btn_state = '0;
    step();
  endtask

  task automatic test_single();
    evt_ready = 1'b1;
    btn_down = 5'b00100;
    step();
    btn_down = '0;
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_lat: valid=%b want 0", evt_valid);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd2 || evt_repeat !== 1'b0) begin
      n_err++;
      $display("FAIL single_evt: v=%b code=%0d rpt=%b want 1 2 0",
               evt_valid, evt_code, evt_repeat);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_simul();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    evt_ready = 1'b0;
    btn_down = 5'b10110;
    step();
    btn_down = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin
        n_err++;
        $display("FAIL simul_stall c=%0d: v=%b code=%0d want 1 1",
                 c, evt_valid, evt_code);
      end
    end
    evt_ready = 1'b1;
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd2) begin
      n_err++;
      $display("FAIL simul_2nd: v=%b code=%0d want 1 2",
               evt_valid, evt_code);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd4 || evt_repeat !== 1'b0) begin
      n_err++;
      $display("FAIL simul_3rd: v=%b code=%0d rpt=%b want 1 4 0",
               evt_valid, evt_code, evt_repeat);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL simul_end: valid=%b want 0", evt_valid);
    end
    evt_ready = 1'b0;
    btn_down = 5'b10001;
    step();
    btn_down = '0;
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd0) begin
      n_err++;
      $display("FAIL simul_ptr: v=%b code=%0d want 1 0",
               evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd4) begin
      n_err++;
      $display("FAIL simul_wrap: v=%b code=%0d want 1 4",
               evt_valid, evt_code);
    end
    step();
  endtask

  task automatic test_drop();
    int got;
    got = 0;
    evt_ready = 1'b0;
    btn_state = '0;
    btn_down = 5'b01000;
    step();
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 3'd3 || evt_drop !== 1'b0) begin
      n_err++;
      $display("FAIL drop_first: v=%b code=%0d drop=%b want 1 3 0",
               evt_valid, evt_code, evt_drop);
    end
    btn_down = '0;
    step();
    n_cmp++;
    if (evt_drop !== 1'b0) begin
      n_err++;
      $display("FAIL drop_early: drop=%b want 0", evt_drop);
    end
    btn_down = 5'b01000;
    step();
    btn_down = '0;
    n_cmp++;
    if (evt_drop !== 1'b1) begin
      n_err++;
      $display("FAIL drop_pulse: drop=%b want 1", evt_drop);
    end
    step();
    n_cmp++;
    if (evt_drop !== 1'b0) begin
      n_err++;
      $display("FAIL drop_width: drop=%b want 0", evt_drop);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (evt_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (evt_code !== 3'd3) begin
          n_err++;
          $display("FAIL drop_code c=%0d: code=%0d want 3", c, evt_code);
        end
      end
      step();
    end
    n_cmp++;
    if (got != 2) begin
      n_err++;
      $display("FAIL drop_count: got %0d events want 2", got);
    end
  endtask

  task automatic test_repeat();
    logic ev;
    evt_ready = 1'b1;
    btn_down = 5'b00010;
    btn_state = 5'b00010;
    step();
    btn_down = '0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) btn_state = '0;
      step();
      ev = (k == 1) || (k == 9) || (k == 13) || (k == 17) || (k == 21);
      n_cmp++;
      if (evt_valid !== ev || evt_drop !== 1'b0) begin
        n_err++;
        $display("FAIL repeat_valid k=%0d: v=%b drop=%b want %b 0",
                 k, evt_valid, evt_drop, ev);
      end
      if (ev) begin
        n_cmp++;
        if (evt_code !== 3'd1 || evt_repeat !== (k != 1)) begin
          n_err++;
          $display("FAIL repeat_evt k=%0d: code=%0d rpt=%b want 1 %b",
                   k, evt_code, evt_repeat, (k != 1));
        end
      end
    end
  endtask

  task automatic test_retarget();
    logic ev;
    logic [2:0] ec;
    logic er;
    evt_ready = 1'b1;
    btn_down = 5'b00001;
    btn_state = 5'b00001;
    step();
    btn_down = '0;
    for (int k = 1; k <= 34; k++) begin
      if (k == 14) begin
        btn_down = 5'b10000;
        btn_state = 5'b10001;
      end
      if (k == 15) btn_down = '0;
      if (k == 28) btn_state = '0;
      step();
      ev = (k == 1) || (k == 9) || (k == 13) ||
           (k == 15) || (k == 23) || (k == 27);
      ec = (k >= 15) ? 3'd4 : 3'd0;
      er = (k != 1) && (k != 15);
      n_cmp++;
      if (evt_valid !== ev) begin
        n_err++;
        $display("FAIL retarget_valid k=%0d: v=%b want %b",
                 k, evt_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (evt_code !== ec || evt_repeat !== er) begin
          n_err++;
          $display("FAIL retarget_evt k=%0d: code=%0d rpt=%b want %0d %b",
                   k, evt_code, evt_repeat, ec, er);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    btn_down = '0;
    btn_state = '0;
    evt_ready = 1'b0;
    test_reset();
    test_single();
    test_simul();
    test_drop();
    test_repeat();
    test_retarget();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
